// File: rtl/psum_out_reader.sv
// Reads psum words 0..outputsize from memory into a small output FIFO and streams them out with tvalid/tready/tlast.
// Optional build macro PSUM_OUT_READER_RELU_EN clamps negative lanes to zero as each word enters the FIFO.
module psum_out_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int MEM_DELAY  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
    output logic [ADDR_WIDTH-1:0] memctrl_radd,
    output logic                  memctrl_rden,
    input  logic [DATA_WIDTH-1:0] memctrl_odat,
    input  logic                  memctrl_ovld,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [MEM_DELAY-1:0]  pend_vld;
    logic [MEM_DELAY-1:0]  pend_last;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W:0]        budget_sum;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   head;

    logic can_issue;
    logic issue_last;
    logic accept;
    logic push;
    logic pop;

    function automatic logic [DATA_WIDTH-1:0] lane_filter(input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] result;
        result = word;
`ifdef PSUM_OUT_READER_RELU_EN
        for (int k = 0; k < NUM_KERNEL; k++) begin
            if (word[k*BIT_WIDTH + BIT_WIDTH - 1]) begin
                result[k*BIT_WIDTH +: BIT_WIDTH] = '0;
            end
        end
`endif
        return result;
    endfunction

    // Reads in flight are counted against FIFO space so returning data always has a slot.
    assign budget_sum   = {1'b0, occ} + {1'b0, inflight};
    assign can_issue    = budget_sum < (CNT_W + 1)'(FIFO_DEPTH);
    assign memctrl_rden = (state == READ) && can_issue;
    assign memctrl_radd = addr;
    assign issue_last   = memctrl_rden && (addr == last_addr);

    // Only data matching a read we issued is accepted, so stale returns after reset are dropped.
    assign accept = pend_vld[MEM_DELAY-1];
    assign push   = accept && memctrl_ovld;

    assign head     = fifo_mem[rd_ptr];
    assign o_tvalid = (occ != '0);
    assign o_tdata  = o_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign o_tlast  = o_tvalid && head[DATA_WIDTH];
    assign pop      = o_tvalid && i_tready;
    assign o_busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = READ;
            READ:    if (issue_last) state_next = DRAIN;
            DRAIN:   if (pop && o_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            pend_vld  <= '0;
            pend_last <= '0;
            inflight  <= '0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_done    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_start) begin
                addr      <= '0;
                last_addr <= ADDR_WIDTH'(i_conf_outputsize);
            end else if (memctrl_rden) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            pend_vld[0]  <= memctrl_rden;
            pend_last[0] <= issue_last;
            for (int i = 1; i < MEM_DELAY; i++) begin
                pend_vld[i]  <= pend_vld[i-1];
                pend_last[i] <= pend_last[i-1];
            end
            inflight <= inflight + CNT_W'(memctrl_rden) - CNT_W'(accept);
            occ      <= occ + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            o_done <= (state == DRAIN) && pop && o_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pend_last[MEM_DELAY-1], lane_filter(memctrl_odat)};
        end
    end

endmodule

// File: tb/tb_psum_out_reader.sv
// Directed bench for psum_out_reader with a one-cycle-latency memory model and handshake monitor.
module tb_psum_out_reader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [RW-1:0] i_conf_outputsize;
    logic [AW-1:0] memctrl_radd;
    logic          memctrl_rden;
    logic [DW-1:0] memctrl_odat;
    logic          memctrl_ovld;
    logic [DW-1:0] o_tdata;
    logic          o_tvalid;
    logic          i_tready;
    logic          o_tlast;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] mem [0:63];

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            got_cyc [$];
    logic [AW-1:0] rd_addr [$];
    int            done_cyc [$];
    logic          done_busy [$];
    int            out_hist [$];
    int            reads = 0;
    int            pops = 0;

    always #5 clk = ~clk;

    psum_out_reader dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_conf_outputsize(i_conf_outputsize),
        .memctrl_radd     (memctrl_radd),
        .memctrl_rden     (memctrl_rden),
        .memctrl_odat     (memctrl_odat),
        .memctrl_ovld     (memctrl_ovld),
        .o_tdata          (o_tdata),
        .o_tvalid         (o_tvalid),
        .i_tready         (i_tready),
        .o_tlast          (o_tlast),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    // Memory answers every read exactly one cycle later
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        memctrl_ovld <= memctrl_rden;
        memctrl_odat <= mem[memctrl_radd[5:0]];
    end

    // Records handshakes, reads, done pulses and outstanding words mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            reads = 0;
            pops  = 0;
        end else begin
            if (o_tvalid && i_tready) begin
                got_data.push_back(o_tdata);
                got_last.push_back(o_tlast);
                got_cyc.push_back(cyc);
                pops++;
            end
            if (memctrl_rden) begin
                rd_addr.push_back(memctrl_radd);
                reads++;
            end
            out_hist.push_back(reads - pops);
            if (o_done) begin
                done_cyc.push_back(cyc);
                done_busy.push_back(o_busy);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int size, output int start_c);
        i_conf_outputsize = RW'(size);
        i_start = 1'b1;
        start_c = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_cyc.size() == base && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 64'(done_cyc.size() > base), 64'd1);
    endtask

    function automatic logic [DW-1:0] dat_at(int i);
        return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic last_at(int i);
        return (i < got_last.size()) ? got_last[i] : 1'bx;
    endfunction

    function automatic int cyc_at(int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1;
    endfunction

    function automatic logic [AW-1:0] addr_at(int i);
        return (i < rd_addr.size()) ? rd_addr[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rden"}, 64'(memctrl_rden), 64'd0);
        checkOutput({tag, "_radd"}, 64'(memctrl_radd), 64'd0);
        checkOutput({tag, "_tvalid"}, 64'(o_tvalid), 64'd0);
        checkOutput({tag, "_tlast"}, 64'(o_tlast), 64'd0);
        checkOutput({tag, "_tdata"}, 64'(o_tdata), 64'd0);
        checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int d0, a0, k0, h0, sc, max_out, stray;
        logic [DW-1:0] relu_exp;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0403_0201 + DW'(i);
        rst = 1'b1;
        i_start = 1'b0;
        i_conf_outputsize = '0;
        i_tready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        $display("[TB] outputsize=7 with tready held high");
        d0 = got_data.size(); a0 = rd_addr.size(); k0 = done_cyc.size();
        applyStimulus(7, sc);
        wait_done(k0, 60);
        checkOutput("t1_count", 64'(got_data.size() - d0), 64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1_data%0d", i), 64'(dat_at(d0 + i)), 64'(32'h0403_0201 + i));
            checkOutput($sformatf("t1_last%0d", i), 64'(last_at(d0 + i)), 64'(i == 7));
            checkOutput($sformatf("t1_addr%0d", i), 64'(addr_at(a0 + i)), 64'(i));
        end
        checkOutput("t1_latency", 64'(cyc_at(d0) - sc), 64'd3);
        checkOutput("t1_back_to_back", 64'(cyc_at(d0 + 7) - cyc_at(d0)), 64'd7);
        checkOutput("t1_done_cycle", 64'(done_cyc[k0]), 64'(cyc_at(d0 + 7) + 1));
        checkOutput("t1_done_idle", 64'(done_busy[k0]), 64'd0);
        tick();
        checkOutput("t1_done_pulse", 64'(o_done), 64'd0);

        $display("[TB] outputsize=15 with tready pattern 1,0,0");
        d0 = got_data.size(); a0 = rd_addr.size(); k0 = done_cyc.size(); h0 = out_hist.size();
        i_tready = 1'b1;
        applyStimulus(15, sc);
        for (int c = 0; c < 300 && done_cyc.size() == k0; c++) begin
            i_tready = ((c % 3) == 2);
            tick();
        end
        i_tready = 1'b1;
        checkOutput("t2_done_seen", 64'(done_cyc.size() > k0), 64'd1);
        checkOutput("t2_count", 64'(got_data.size() - d0), 64'd16);
        checkOutput("t2_reads", 64'(rd_addr.size() - a0), 64'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t2_data%0d", i), 64'(dat_at(d0 + i)), 64'(32'h0403_0201 + i));
            checkOutput($sformatf("t2_addr%0d", i), 64'(addr_at(a0 + i)), 64'(i));
        end
        checkOutput("t2_last15", 64'(last_at(d0 + 15)), 64'd1);
        checkOutput("t2_last14", 64'(last_at(d0 + 14)), 64'd0);
        max_out = 0;
        for (int i = h0; i < out_hist.size(); i++) if (out_hist[i] > max_out) max_out = out_hist[i];
        checkOutput("t2_max_outstanding", 64'(max_out), 64'd4);
        tick();

        $display("[TB] second start during READ is ignored");
        d0 = got_data.size(); k0 = done_cyc.size();
        applyStimulus(9, sc);
        tick();
        i_conf_outputsize = RW'(2);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_conf_outputsize = RW'(5);
        wait_done(k0, 60);
        checkOutput("t3_count", 64'(got_data.size() - d0), 64'd10);
        checkOutput("t3_data9", 64'(dat_at(d0 + 9)), 64'h0403_020A);
        checkOutput("t3_last9", 64'(last_at(d0 + 9)), 64'd1);
        checkOutput("t3_last2", 64'(last_at(d0 + 2)), 64'd0);
        tick();

        $display("[TB] outputsize=0 single word");
        d0 = got_data.size(); k0 = done_cyc.size();
        applyStimulus(0, sc);
        wait_done(k0, 30);
        checkOutput("t4_count", 64'(got_data.size() - d0), 64'd1);
        checkOutput("t4_data", 64'(dat_at(d0)), 64'h0403_0201);
        checkOutput("t4_last", 64'(last_at(d0)), 64'd1);
        checkOutput("t4_done_cycle", 64'(done_cyc[k0]), 64'(cyc_at(d0) + 1));
        tick();

        $display("[TB] reset after three of ten words");
        d0 = got_data.size(); k0 = done_cyc.size();
        applyStimulus(9, sc);
        for (int c = 0; c < 30 && (got_data.size() - d0) < 3; c++) tick();
        checkOutput("t5_three_words", 64'((got_data.size() - d0) >= 3), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("t5_reset");
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_tvalid || o_done || o_busy) stray++;
        end
        checkOutput("t5_quiet_after_reset", 64'(stray), 64'd0);
        checkOutput("t5_no_done", 64'(done_cyc.size() - k0), 64'd0);
        d0 = got_data.size(); a0 = rd_addr.size(); k0 = done_cyc.size();
        applyStimulus(2, sc);
        wait_done(k0, 30);
        checkOutput("t5_count", 64'(got_data.size() - d0), 64'd3);
        checkOutput("t5_addr0", 64'(addr_at(a0)), 64'd0);
        checkOutput("t5_data0", 64'(dat_at(d0)), 64'h0403_0201);
        checkOutput("t5_data2", 64'(dat_at(d0 + 2)), 64'h0403_0203);
        tick();

        $display("[TB] lane filter on a word with negative lanes");
`ifdef PSUM_OUT_READER_RELU_EN
        relu_exp = 32'h0000_7F01;
`else
        relu_exp = 32'h80FF_7F01;
`endif
        mem[0] = 32'h80FF_7F01;
        d0 = got_data.size(); k0 = done_cyc.size();
        applyStimulus(0, sc);
        wait_done(k0, 30);
        checkOutput("t6_data", 64'(dat_at(d0)), 64'(relu_exp));
        mem[0] = 32'h0403_0201;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_out_reader.md
PSUM_OUT_READER -- requirements
Module: psum_out_reader

Interface
REQ-001 Parameter: DATA_WIDTH, 32, memory word width (NUM_KERNEL x BIT_WIDTH).
REQ-002 Parameter: ADDR_WIDTH, 32, memory address width.
REQ-003 Parameter: REG_WIDTH, 32, config register width.
REQ-004 Parameter: BIT_WIDTH, 8, per-kernel psum lane width (signed two's complement).
REQ-005 Parameter: NUM_KERNEL, 4, lanes per word.
REQ-006 Parameter: MEM_DELAY, 1, fixed read latency in cycles from rden to ovld.
REQ-007 Parameter: FIFO_DEPTH, 4, output buffer entries (power of two, >= MEM_DELAY+1).
REQ-008 clk  in  1  clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 i_start  in  1  one-cycle pulse that starts readback (driven from accumulator o_done).
REQ-011 i_conf_outputsize  in  REG_WIDTH  index of the last word; readback covers addresses 0..i_conf_outputsize inclusive.
REQ-012 memctrl_radd  out  ADDR_WIDTH  read address.
REQ-013 memctrl_rden  out  1  read strobe.
REQ-014 memctrl_odat  in  DATA_WIDTH  read data.
REQ-015 memctrl_ovld  in  1  read data valid, exactly MEM_DELAY cycles after rden.
REQ-016 o_tdata  out  DATA_WIDTH  output word, lane k at bits [8k+7:8k].
REQ-017 o_tvalid  out  1  output valid.
REQ-018 i_tready  in  1  downstream ready.
REQ-019 o_tlast  out  1  high with the word read from address i_conf_outputsize.
REQ-020 o_busy  out  1  high in states other than IDLE.
REQ-021 o_done  out  1  one-cycle pulse on completion.

Function
REQ-022 FSM states IDLE, READ, DRAIN; IDLE->READ on i_start; READ->DRAIN once the read for the last address is issued; DRAIN->IDLE once the tlast word handshakes (o_tvalid & i_tready).
REQ-023 i_start is latched only in IDLE; i_start in READ/DRAIN is ignored.
REQ-024 On entering READ, the word count is captured from i_conf_outputsize; later changes to the config have no effect until the next start.
REQ-025 Read addresses count 0,1,...,outputsize; one read per cycle maximum; no address wraps or repeats.
REQ-026 A read issues only if (FIFO occupancy + reads in flight) < FIFO_DEPTH, so the FIFO never overflows and ovld data is never dropped.
REQ-027 Every memctrl_ovld pushes one FIFO entry; a push and a pop in the same cycle leave occupancy unchanged.
REQ-028 o_tvalid = FIFO not empty; o_tdata/o_tlast = FIFO head; the head is held stable while o_tvalid & ~i_tready.
REQ-029 The tlast flag is stored per entry and is set for the entry of the final address only.
REQ-030 With i_tready held high, sustained throughput is one word per cycle; start-to-first-o_tvalid latency is MEM_DELAY+2 cycles.
REQ-031 o_done pulses one cycle after the tlast handshake; the FSM is in IDLE in that same cycle and accepts a new i_start.
REQ-032 outputsize=0: exactly one word is transferred, with o_tlast=1.

Reset
REQ-033 While rst is asserted: FSM=IDLE, address counter=0, FIFO empty, in-flight count=0, memctrl_rden=0, memctrl_radd=0, o_tvalid=0, o_tlast=0, o_tdata=0, o_busy=0, o_done=0.
REQ-034 Reset mid-operation aborts the transfer; memctrl_ovld arriving after reset is discarded, and no o_done is produced.

Configuration
REQ-035 Macro PSUM_OUT_READER_RELU_EN: when defined, each lane is ReLU'd on FIFO push (negative lanes -> 8'h00, others unchanged); when undefined, data passes bit-exact. Latency is identical in both builds.

Verification
REQ-036 outputsize=7, memory[i]=32'h0403_0201+i, tready=1 -> 8 words on consecutive cycles, addresses 0..7, tlast on the 8th, o_done one cycle later.
REQ-037 outputsize=15, tready toggling 1,0,0,1... -> no lost or duplicated words, FIFO never exceeds 4 entries, rden throttles while full.
REQ-038 outputsize=0 -> single word with tlast=1, then o_done.
REQ-039 Second i_start in the middle of READ -> ignored; the word count is unchanged.
REQ-040 rst asserted after 3 of 10 words -> all outputs return to reset values next cycle, no o_done; a new start re-reads from address 0.
REQ-041 memory word 32'h80FF_7F01 -> output 32'h0000_7F01 with PSUM_OUT_READER_RELU_EN defined, 32'h80FF_7F01 without it.
